// File: rtl/tart_capture_pkg.sv
// tart_capture_pkg: shared constants, output FSM encoding and sample sizing for the capture framer
package tart_capture_pkg;
   localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;
   localparam int HEAD_BYTES = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_HEAD, ST_DATA, ST_XSUM} state_t;
   function automatic int sbytes(input int ant);
      return (2 * ant + 7) / 8;
   endfunction
endpackage

// File: rtl/sig_capture_framer_if.sv
// sig_capture_framer_if: 8-bit AXI-Stream byte channel
interface sig_capture_framer_if;
   logic       tvalid;
   logic       tready;
   logic       tlast;
   logic [7:0] tdata;
   modport master (output tvalid, tlast, tdata, input tready);
   modport slave (input tvalid, tlast, tdata, output tready);
endinterface

// File: rtl/sig_sample_fifo.sv
// sig_sample_fifo: first-word fall-through sample FIFO of 2**ABITS words
module sig_sample_fifo #(
   parameter int WIDTH = 48,
   parameter int ABITS = 4
) (
   input  logic             clock,
   input  logic             arst_n,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [2**ABITS];
   logic [ABITS-1:0] wptr, rptr;
   logic [ABITS:0]   count;
   assign rdata = mem[rptr];
   assign full  = count[ABITS];
   assign empty = count == '0;
   always_ff @(posedge clock)
      if (wr) mem[wptr] <= wdata;
   always_ff @(posedge clock or negedge arst_n)
      if (!arst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + ABITS'(wr);
         rptr  <= rptr + ABITS'(rd);
         count <= count + (ABITS+1)'(wr) - (ABITS+1)'(rd);
      end
endmodule

// File: rtl/sig_capture_framer.sv
// sig_capture_framer: TART raw-signal capture framer, antenna samples -> framed 8-bit AXI-Stream.
// Define SIG_CAPTURE_XSUM_EN to append an XOR checksum byte (carrying tlast) to every frame.
module sig_capture_framer
   import tart_capture_pkg::*;
#(
   parameter int          ANTENNAS      = 24,
   parameter int          FRAME_SAMPLES = 256,
   parameter int          FIFO_ABITS    = 4,
   parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEF
) (
   input  logic                clock,
   input  logic                arst_n,
   input  logic                cap_enable_i,
   input  logic                sig_valid_i,
   input  logic [ANTENNAS-1:0] sig_idata_i,
   input  logic [ANTENNAS-1:0] sig_qdata_i,
   sig_capture_framer_if.master m,
   output logic                frame_busy_o,
   output logic [15:0]         ovf_count_o
);
   localparam int SB  = sbytes(ANTENNAS);
   localparam int W   = SB * 8;
   localparam int SCW = $clog2(FRAME_SAMPLES + 1);
   localparam int BCW = $clog2(SB + 1);
   state_t         state;
   logic           frame_open, ovf, full, empty, accept, wr, rd, adv, drop;
   logic [SCW-1:0] wcnt, scnt;
   logic [BCW-1:0] bcnt;
   logic [1:0]     hcnt;
   logic [14:0]    seq;
   logic [7:0]     xsum, hbyte, dbyte;
   logic [W-1:0]   word, rdata;
   assign word   = W'({sig_qdata_i, sig_idata_i});
   assign adv    = !m.tvalid || m.tready;
   // A word leaves the FIFO as soon as its last byte is latched into the output register.
   assign rd     = adv && state == ST_DATA && !empty && bcnt == BCW'(SB - 1);
   assign accept = sig_valid_i && (cap_enable_i || frame_open);
   assign wr     = accept && (!full || rd);
   assign drop   = accept && !wr;
   assign frame_busy_o = frame_open || state != ST_IDLE || m.tvalid;
   assign hbyte  = hcnt == 2'd1 ? SYNC_WORD[7:0] : hcnt == 2'd2 ? seq[7:0] : {ovf, seq[14:8]};
   assign dbyte  = rdata[8*bcnt +: 8];
   sig_sample_fifo #(.WIDTH(W), .ABITS(FIFO_ABITS)) u_fifo (
      .clock(clock), .arst_n(arst_n), .wr(wr), .wdata(word), .rd(rd),
      .rdata(rdata), .full(full), .empty(empty)
   );
   always_ff @(posedge clock or negedge arst_n)
      if (!arst_n) begin
         frame_open  <= 1'b0;
         wcnt        <= '0;
         ovf_count_o <= '0;
      end else begin
         if (wr) begin
            wcnt       <= wcnt == SCW'(FRAME_SAMPLES - 1) ? '0 : wcnt + 1'b1;
            frame_open <= wcnt != SCW'(FRAME_SAMPLES - 1);
         end
         if (drop && ovf_count_o != 16'hFFFF) ovf_count_o <= ovf_count_o + 1'b1;
      end
   always_ff @(posedge clock or negedge arst_n)
      if (!arst_n) begin
         state    <= ST_IDLE;
         hcnt     <= '0;
         bcnt     <= '0;
         scnt     <= '0;
         seq      <= '0;
         xsum     <= '0;
         ovf      <= 1'b0;
         m.tvalid <= 1'b0;
         m.tlast  <= 1'b0;
         m.tdata  <= '0;
      end else begin
         if (adv && state == ST_HEAD && hcnt == 2'(HEAD_BYTES - 1)) ovf <= 1'b0;
         if (drop) ovf <= 1'b1;
         if (adv)
            case (state)
               ST_IDLE: begin
                  m.tvalid <= !empty;
                  m.tlast  <= 1'b0;
                  if (!empty) begin
                     m.tdata <= SYNC_WORD[15:8];
                     xsum    <= SYNC_WORD[15:8];
                     hcnt    <= 2'd1;
                     state   <= ST_HEAD;
                  end
               end
               ST_HEAD: begin
                  m.tdata <= hbyte;
                  xsum    <= xsum ^ hbyte;
                  hcnt    <= hcnt + 1'b1;
                  if (hcnt == 2'(HEAD_BYTES - 1)) begin
                     bcnt  <= '0;
                     scnt  <= '0;
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  m.tvalid <= !empty;
                  if (!empty) begin
                     m.tdata <= dbyte;
                     xsum    <= xsum ^ dbyte;
                     bcnt    <= rd ? '0 : bcnt + 1'b1;
                     if (rd) begin
                        scnt <= scnt + 1'b1;
                        if (scnt == SCW'(FRAME_SAMPLES - 1)) begin
`ifdef SIG_CAPTURE_XSUM_EN
                           state <= ST_XSUM;
`else
                           m.tlast <= 1'b1;
                           seq     <= seq + 1'b1;
                           state   <= ST_IDLE;
`endif
                        end
                     end
                  end
               end
               default: begin
                  m.tdata <= xsum;
                  m.tlast <= 1'b1;
                  seq     <= seq + 1'b1;
                  state   <= ST_IDLE;
               end
            endcase
      end
endmodule

// File: tb/tb_sig_capture_framer.sv
// tb_sig_capture_framer: random + directed bench with a byte-stream reference model of the framer
module tb_sig_capture_framer;
   localparam int ANT = 24, FS = 2, AB = 2, DEPTH = 4, SB = 6;
`ifdef SIG_CAPTURE_XSUM_EN
   localparam int XS = 1;
`else
   localparam int XS = 0;
`endif
   localparam int L = 4 + SB * FS + XS;
   logic clock = 0, arst_n = 0, en = 0, valid = 0;
   logic [23:0] idata = 0, qdata = 0;
   logic busy;
   logic [15:0] ovf_count;
   int checks = 0, failures = 0;
   sig_capture_framer_if bus();
   sig_capture_framer #(.ANTENNAS(ANT), .FRAME_SAMPLES(FS), .FIFO_ABITS(AB)) dut (
      .clock(clock), .arst_n(arst_n), .cap_enable_i(en), .sig_valid_i(valid),
      .sig_idata_i(idata), .sig_qdata_i(qdata), .m(bus.master),
      .frame_busy_o(busy), .ovf_count_o(ovf_count)
   );
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Reference model: accepted samples, position in the frame, sequence number, sticky overflow
   logic [47:0] acc_q[$];
   logic [7:0]  log_q[$];
   bit          last_q[$];
   int k = 0, seq_m = 0, in_frame = 0, exp_ovf = 0;
   bit ovf_m = 0, prev_stall = 0, prev_last = 0;
   logic [7:0] xs_m = 0, prev_data = 0;
   function automatic int outstanding();
      int d = (k >= 4) ? (k - 4) / SB : 0;
      if (d > FS) d = FS;
      return acc_q.size() - d;
   endfunction
   always @(negedge clock) begin
      logic [7:0]  eb;
      logic [47:0] w;
      int si;
      if (!arst_n) begin
         acc_q.delete();
         k = 0; seq_m = 0; in_frame = 0; exp_ovf = 0; ovf_m = 0; prev_stall = 0; xs_m = 0;
      end else begin
         chk("ovf_count", ovf_count, exp_ovf);
         if (prev_stall) begin
            chk("stall_valid", bus.tvalid, 1);
            chk("stall_data", bus.tdata, prev_data);
            chk("stall_last", bus.tlast, prev_last);
         end
         prev_stall = bus.tvalid && !bus.tready;
         prev_data = bus.tdata;
         prev_last = bus.tlast;
         if (bus.tvalid && bus.tready) begin
            eb = 8'h00;
            if (k < 4) eb = k == 0 ? 8'hA5 : k == 1 ? 8'h5A : k == 2 ? seq_m[7:0] : {ovf_m, seq_m[14:8]};
            else if (k < 4 + SB * FS) begin
               si = (k - 4) / SB;
               if (si >= acc_q.size()) begin
                  checks++;
                  failures++;
                  $display("FAIL data_src: frame byte %0d got %0h but expected no byte (sample not accepted)", k, bus.tdata);
               end else begin
                  w = acc_q[si];
                  eb = w[8*((k-4)%SB) +: 8];
               end
            end else eb = xs_m;
            chk("tdata", bus.tdata, eb);
            chk("tlast", bus.tlast, k == L - 1);
            if (k == 3) ovf_m = 0;
            xs_m = (k == 0) ? eb : xs_m ^ eb;
            log_q.push_back(bus.tdata);
            last_q.push_back(bus.tlast);
            if (k == L - 1) begin
               k = 0;
               seq_m = (seq_m + 1) % 32768;
               repeat (FS) if (acc_q.size() > 0) void'(acc_q.pop_front());
            end else k++;
         end
         if (valid && (en || in_frame != 0)) begin
            if (outstanding() >= DEPTH) begin
               ovf_m = 1;
               if (exp_ovf < 65535) exp_ovf++;
            end else begin
               acc_q.push_back({qdata, idata});
               in_frame = (in_frame + 1) % FS;
            end
         end
      end
   end
   int rmode = 0, cyc = 0;
   initial begin
      bus.tready = 1;
      forever begin
         @(posedge clock); #1;
         cyc++;
         case (rmode)
            0: bus.tready = 1;
            1: bus.tready = (cyc % 3 == 0);
            2: bus.tready = ($urandom_range(0, 3) != 0);
            default: bus.tready = 0;
         endcase
      end
   end
   task automatic send(input logic [23:0] i, input logic [23:0] q);
      @(posedge clock); #1;
      valid = 1; idata = i; qdata = q;
      @(posedge clock); #1;
      valid = 0;
   endtask
   task automatic wait_idle(input string name);
      int n = 0;
      repeat (3) @(negedge clock);
      while ((busy || bus.tvalid || acc_q.size() != 0 || k != 0) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk({name, "_drain"}, 32'(n < 3000), 1);
   endtask
   logic [7:0] exp1 [16];
   int base;
   initial begin
      exp1 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
      en = 1;
      repeat (3) @(negedge clock);
      chk("rst_tvalid", bus.tvalid, 0);
      chk("rst_tlast", bus.tlast, 0);
      chk("rst_tdata", bus.tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf_count, 0);
      arst_n = 1;
      for (int t = 1; t <= 2; t++) begin
         rmode = t - 1;
         base = log_q.size();
         send(24'h000001, 24'h0);
         if (t == 1) begin
            @(negedge clock); chk("lat_pre", bus.tvalid, 0);
            @(negedge clock); chk("lat_valid", bus.tvalid, 1); chk("lat_byte0", bus.tdata, 8'hA5);
         end
         repeat (6) @(posedge clock);
         send(24'h0, 24'h800000);
         wait_idle("frame");
         exp1[2] = 8'(t - 1);
         chk("frame_len", log_q.size() - base, L);
         for (int i = 0; i < 16; i++) chk("frame_byte", log_q[base+i], exp1[i]);
         chk("frame_last", last_q[base+L-1], 1);
         chk("frame_notlast", last_q[base+L-2], 0);
`ifdef SIG_CAPTURE_XSUM_EN
         if (t == 1) chk("xsum_byte", log_q[base+16], 8'h7E);
`endif
      end
      rmode = 0;
      base = log_q.size();
      send(24'h123456, 24'h654321);
      en = 0;
      @(negedge clock); chk("t4_busy_open", busy, 1);
      send(24'hABCDEF, 24'h0F0F0F);
      wait_idle("t4");
      chk("t4_len", log_q.size() - base, L);
      chk("t4_busy_done", busy, 0);
      send(24'h111111, 24'h222222);
      begin
         int seen = 0;
         repeat (10) begin @(negedge clock); if (bus.tvalid || busy) seen++; end
         chk("t4_ignored", seen, 0);
      end
      rmode = 2;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clock); #1;
         en = $urandom_range(0, 7) != 0;
         valid = outstanding() <= DEPTH - 2 && $urandom_range(0, 2) == 0;
         idata = 24'($urandom);
         qdata = 24'($urandom);
      end
      @(posedge clock); #1;
      valid = 0;
      rmode = 0;
      en = 1;
      while (in_frame != 0) send(24'($urandom), 24'($urandom));
      wait_idle("rand");
      rmode = 3;
      repeat (2) @(posedge clock);
      for (int i = 0; i < 7; i++) send(24'(i + 1), 24'(i * 3));
      @(negedge clock); chk("t3_ovf_count", ovf_count, 3);
      base = log_q.size();
      rmode = 0;
      wait_idle("t3");
      chk("t3_len", log_q.size() - base, 2 * L);
      chk("t3_ovf_bit", log_q[base+3] & 8'h80, 8'h80);
      chk("t3_ovf_clr", log_q[base+L+3] & 8'h80, 8'h00);
      base = log_q.size();
      send(24'hFFFFFF, 24'hFFFFFF);
      send(24'h00FF00, 24'hFF00FF);
      begin
         int n = 0;
         while (log_q.size() < base + 6 && n < 200) begin @(negedge clock); n++; end
         chk("t5_reach_data", 32'(n < 200), 1);
      end
      @(negedge clock); #2;
      arst_n = 0;
      @(negedge clock);
      chk("t5_tvalid", bus.tvalid, 0);
      chk("t5_tlast", bus.tlast, 0);
      chk("t5_tdata", bus.tdata, 0);
      chk("t5_busy", busy, 0);
      chk("t5_ovf", ovf_count, 0);
      #2 arst_n = 1;
      base = log_q.size();
      send(24'h0A0B0C, 24'h0D0E0F);
      send(24'h102030, 24'h405060);
      wait_idle("t5");
      chk("t5_len", log_q.size() - base, L);
      chk("t5_seq", log_q[base+2], 8'h00);
      chk("t5_byte3", log_q[base+3], 8'h00);
      chk("t5_ovf_after", ovf_count, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
